sc_level_lives_tracker: RTL and testbench

Datapath and status responder for the general game state machine. It receives the FSM's active-low level-advance and life-lost strobes and keeps the level and lives counters. It applies a post-hit invulnerability holdoff. It returns the status flags the FSM consumes: level-limit comparator and losing indication. It sits between the general FSM and the score/7-segment display logic.

---
 rtl/sc_level_lives_tracker.sv | 118 +++++++++++
 tb/tb_sc_level_lives_tracker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_level_lives_tracker.sv
// Level/lives datapath for the general game FSM: edge-detects the active-low strobes, applies post-hit holdoff.
// Events update state on the edge where the strobe is first sampled low; outputs decode registered state only.
module sc_level_lives_tracker #(
  parameter int LEVEL_WIDTH    = 3,
  parameter int MAX_LEVEL      = 4,
  parameter int LIVES_WIDTH    = 2,
  parameter int INIT_LIVES     = 3,
  parameter int HOLDOFF_CYCLES = 50000000
) (
  input  logic                   SC_STATEMACHINEGENERAL_CLOCK_50,
  input  logic                   SC_STATEMACHINEGENERAL_RESET_InHigh,
  input  logic                   clear_InLow,
  input  logic                   contador_niveles_InLow,
  input  logic                   contador_vidas_InLow,
  output logic [LEVEL_WIDTH-1:0] level_Out,
  output logic [LIVES_WIDTH-1:0] lives_Out,
  output logic                   COMPARATOR_LEVELS_Out,
  output logic                   Losing_OutLow,
  output logic                   holdoff_busy_Out
);

  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [1:0] ST_PLAY     = 2'd0;
  localparam logic [1:0] ST_HOLDOFF  = 2'd1;
  localparam logic [1:0] ST_WIN      = 2'd2;
  localparam logic [1:0] ST_GAMEOVER = 2'd3;

  localparam logic [LEVEL_WIDTH-1:0] MAX_LEVEL_C  = LEVEL_WIDTH'(MAX_LEVEL);
  localparam logic [LIVES_WIDTH-1:0] INIT_LIVES_C = LIVES_WIDTH'(INIT_LIVES);
  localparam logic [HOLD_W-1:0]      HOLD_LOAD    = HOLD_W'(HOLDOFF_CYCLES - 1);

  logic [1:0]             state, state_nxt;
  logic [LEVEL_WIDTH-1:0] level, level_nxt, level_inc;
  logic [LIVES_WIDTH-1:0] lives, lives_nxt, lives_dec;
  logic [HOLD_W-1:0]      hold_cnt, hold_nxt;
  logic                   prev_niveles, prev_vidas;
  logic                   lvl_ev, vid_ev;

  // Falling-edge detect: a strobe held low counts once.
  assign lvl_ev    = prev_niveles & ~contador_niveles_InLow;
  assign vid_ev    = prev_vidas & ~contador_vidas_InLow;
  assign level_inc = level + LEVEL_WIDTH'(1);
  assign lives_dec = (lives == '0) ? '0 : lives - LIVES_WIDTH'(1);

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    lives_nxt = lives;
    hold_nxt  = hold_cnt;
    if (!clear_InLow) begin
      state_nxt = ST_PLAY;
      level_nxt = '0;
      lives_nxt = INIT_LIVES_C;
      hold_nxt  = '0;
    end else begin
      case (state)
        ST_PLAY: begin
          // A hit wins over a same-cycle level-up; the level event is dropped.
          if (vid_ev) begin
            lives_nxt = lives_dec;
            if (lives_dec == '0) begin
              state_nxt = ST_GAMEOVER;
            end else begin
              state_nxt = ST_HOLDOFF;
              hold_nxt  = HOLD_LOAD;
            end
          end else if (lvl_ev) begin
            level_nxt = level_inc;
            if (level_inc == MAX_LEVEL_C) state_nxt = ST_WIN;
          end
        end
        ST_HOLDOFF: begin
          if (lvl_ev) level_nxt = level_inc;
          if (lvl_ev && level_inc == MAX_LEVEL_C) begin
            state_nxt = ST_WIN;
            hold_nxt  = '0;
          end else if (hold_cnt == '0) begin
            state_nxt = ST_PLAY;
          end else begin
            hold_nxt = hold_cnt - HOLD_W'(1);
          end
        end
        ST_WIN, ST_GAMEOVER: begin
          state_nxt = state;
        end
        default: begin
          state_nxt = ST_PLAY;
        end
      endcase
    end
  end

  always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
    if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
      state        <= ST_PLAY;
      level        <= '0;
      lives        <= INIT_LIVES_C;
      hold_cnt     <= '0;
      prev_niveles <= 1'b1;
      prev_vidas   <= 1'b1;
    end else begin
      state        <= state_nxt;
      level        <= level_nxt;
      lives        <= lives_nxt;
      hold_cnt     <= hold_nxt;
      prev_niveles <= contador_niveles_InLow;
      prev_vidas   <= contador_vidas_InLow;
    end
  end

  assign level_Out             = level;
  assign lives_Out             = lives;
  assign COMPARATOR_LEVELS_Out = (state == ST_WIN);
  assign Losing_OutLow         = (state != ST_GAMEOVER);
  assign holdoff_busy_Out      = (state == ST_HOLDOFF);

endmodule

// File: tb/tb_sc_level_lives_tracker.sv
// Bench for sc_level_lives_tracker: directed scenarios plus randomized strobes against a game-rule model.
module tb_sc_level_lives_tracker;

  localparam int LW   = 3;
  localparam int MAXL = 4;
  localparam int VW   = 2;
  localparam int INIT = 3;
  localparam int HOLD = 4;

  logic          clk;
  logic          rst;
  logic          clear_n;
  logic          niv;
  logic          vid;
  logic [LW-1:0] level_o;
  logic [VW-1:0] lives_o;
  logic          comp_o;
  logic          losing_n_o;
  logic          busy_o;

  int n_cmp = 0;
  int n_err = 0;

  // Game-rule model: counters plus "won", "lost" and remaining holdoff cycles.
  int m_level, m_lives, m_hold;
  bit m_won, m_lost, m_pn, m_pv;

  sc_level_lives_tracker #(
    .LEVEL_WIDTH(LW), .MAX_LEVEL(MAXL), .LIVES_WIDTH(VW),
    .INIT_LIVES(INIT), .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .SC_STATEMACHINEGENERAL_CLOCK_50(clk),
    .SC_STATEMACHINEGENERAL_RESET_InHigh(rst),
    .clear_InLow(clear_n),
    .contador_niveles_InLow(niv),
    .contador_vidas_InLow(vid),
    .level_Out(level_o),
    .lives_Out(lives_o),
    .COMPARATOR_LEVELS_Out(comp_o),
    .Losing_OutLow(losing_n_o),
    .holdoff_busy_Out(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_level = 0; m_lives = INIT; m_hold = 0;
    m_won = 0; m_lost = 0; m_pn = 1; m_pv = 1;
  endtask

  // Drive one cycle of inputs, advance the model on the edge, return #1 after it.
  task automatic step(input logic c, input logic n, input logic v);
    bit lvl, hit;
    clear_n = c; niv = n; vid = v;
    @(posedge clk);
    lvl = m_pn && !n;
    hit = m_pv && !v;
    m_pn = n; m_pv = v;
    if (!c) begin
      m_level = 0; m_lives = INIT; m_hold = 0; m_won = 0; m_lost = 0;
    end else if (m_won || m_lost) begin
      // game over either way: nothing moves
    end else if (m_hold > 0) begin
      if (lvl) m_level++;
      if (m_level == MAXL) begin
        m_won = 1; m_hold = 0;
      end else begin
        m_hold--;
      end
    end else if (hit) begin
      m_lives--;
      if (m_lives == 0) m_lost = 1;
      else m_hold = HOLD;
    end else if (lvl) begin
      m_level++;
      if (m_level == MAXL) m_won = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_n = 1'b1; niv = 1'b1; vid = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    n_cmp++;
    if (level_o !== 3'd0 || lives_o !== 2'd3 || comp_o !== 1'b0 || losing_n_o !== 1'b1 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_init: got lvl=%0d lives=%0d comp=%b los=%b busy=%b want 0 3 0 1 0",
               level_o, lives_o, comp_o, losing_n_o, busy_o);
    end
    step(1, 0, 1); step(1, 1, 1); step(1, 1, 0); step(1, 1, 1);
    n_cmp++;
    if (level_o !== 3'd1 || lives_o !== 2'd2 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_setup: got lvl=%0d lives=%0d busy=%b want 1 2 1", level_o, lives_o, busy_o);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (level_o !== 3'd0 || lives_o !== 2'd3 || comp_o !== 1'b0 || losing_n_o !== 1'b1 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async_holdoff: got lvl=%0d lives=%0d comp=%b los=%b busy=%b want 0 3 0 1 0",
               level_o, lives_o, comp_o, losing_n_o, busy_o);
    end
    @(negedge clk) rst = 1'b0;
    model_reset();
  endtask

  task automatic test_levels();
    step(0, 1, 1);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 5; c++) begin
        step(1, 0, 1);
        if (c == 0) begin
          n_cmp++;
          if (level_o !== 3'(s + 1) || comp_o !== (s == 3)) begin
            n_err++;
            $display("FAIL level_strobe%0d: got lvl=%0d comp=%b want %0d %b", s, level_o, comp_o, s + 1, s == 3);
          end
        end
      end
      step(1, 1, 1); step(1, 1, 1);
    end
    repeat (2) begin
      step(1, 0, 1); step(1, 1, 1);
    end
    n_cmp++;
    if (level_o !== 3'd4 || comp_o !== 1'b1) begin
      n_err++;
      $display("FAIL level_frozen_win: got lvl=%0d comp=%b want 4 1", level_o, comp_o);
    end
  endtask

  task automatic test_holdoff();
    logic v_tab [8] = '{0, 1, 0, 1, 1, 1, 0, 1};
    logic b_tab [8] = '{1, 1, 1, 1, 0, 0, 1, 1};
    int   l_tab [8] = '{2, 2, 2, 2, 2, 2, 1, 1};
    int   busy_cnt = 0;
    step(0, 1, 1);
    for (int e = 0; e < 8; e++) begin
      step(1, 1, v_tab[e]);
      if (e < 6 && busy_o === 1'b1) busy_cnt++;
      n_cmp++;
      if (busy_o !== b_tab[e] || lives_o !== 2'(l_tab[e])) begin
        n_err++;
        $display("FAIL holdoff_e%0d: got busy=%b lives=%0d want %b %0d", e, busy_o, lives_o, b_tab[e], l_tab[e]);
      end
    end
    n_cmp++;
    if (busy_cnt != HOLD) begin
      n_err++;
      $display("FAIL holdoff_len: got %0d busy cycles want %0d", busy_cnt, HOLD);
    end
  endtask

  task automatic test_gameover();
    step(0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0);
      repeat (HOLD) step(1, 1, 1);
      n_cmp++;
      if (lives_o !== 2'(2 - k) || losing_n_o !== (k != 2) || busy_o !== 1'b0) begin
        n_err++;
        $display("FAIL gameover_hit%0d: got lives=%0d los=%b busy=%b want %0d %b 0",
                 k, lives_o, losing_n_o, busy_o, 2 - k, k != 2);
      end
    end
    repeat (2) begin
      step(1, 0, 1); step(1, 1, 1);
    end
    n_cmp++;
    if (level_o !== 3'd0 || losing_n_o !== 1'b0) begin
      n_err++;
      $display("FAIL gameover_frozen: got lvl=%0d los=%b want 0 0", level_o, losing_n_o);
    end
  endtask

  task automatic test_clear_gameover();
    step(0, 0, 1);
    n_cmp++;
    if (level_o !== 3'd0 || lives_o !== 2'd3 || losing_n_o !== 1'b1) begin
      n_err++;
      $display("FAIL clear_dominates: got lvl=%0d lives=%0d los=%b want 0 3 1", level_o, lives_o, losing_n_o);
    end
    step(1, 0, 1);
    n_cmp++;
    if (level_o !== 3'd0) begin
      n_err++;
      $display("FAIL clear_held_strobe: got lvl=%0d want 0", level_o);
    end
    step(1, 1, 1);
  endtask

  task automatic test_simultaneous();
    step(0, 1, 1);
    step(1, 0, 1); step(1, 1, 1);
    step(1, 0, 0);
    n_cmp++;
    if (lives_o !== 2'd2 || level_o !== 3'd1 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL both_strobes: got lives=%0d lvl=%0d busy=%b want 2 1 1", lives_o, level_o, busy_o);
    end
    step(1, 1, 1);
  endtask

  task automatic test_random();
    logic c, n, v;
    for (int i = 0; i < 3000; i++) begin
      c = ($urandom_range(0, 63) != 0);
      n = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 4) != 0);
      step(c, n, v);
      n_cmp++;
      if (level_o !== 3'(m_level) || lives_o !== 2'(m_lives) || comp_o !== m_won ||
          losing_n_o !== !m_lost || busy_o !== (m_hold > 0)) begin
        n_err++;
        $display("FAIL random_c%0d: got lvl=%0d lives=%0d comp=%b los=%b busy=%b want %0d %0d %b %b %b",
                 i, level_o, lives_o, comp_o, losing_n_o, busy_o,
                 m_level, m_lives, m_won, !m_lost, m_hold > 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_levels();
    test_holdoff();
    test_gameover();
    test_clear_gameover();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
